rns_demux_1_2_4bit: RTL and testbench
=====================================

// Module: rns_demux_1_2_4bit
// PURPOSE
//  Streaming 1-to-2 demultiplexer for 4-bit residue digits; the inverse of the 2:1 residue mux.
//  Steers one valid/ready input stream onto two output lanes (A, B).
//  Each lane has its own small FIFO so one stalled lane does not lose data.
//  Routing comes from a per-word select, or from round-robin alternation when alt_en=1.
//  Sits between a residue source and two per-modulus processing channels.
// PARAMETERS
//  WIDTH  4  data width of one residue digit
//  DEPTH  2  entries per lane FIFO; power of 2, >=2
// PORTS
//  clk          in   1      rising-edge clock; only clock
//  rst_n        in   1      synchronous reset, active-low
//  in_valid     in   1      input word present
//  in_ready     out  1      input word accepted this cycle when in_valid & in_ready
//  in_data      in   WIDTH  input residue digit
//  in_sel       in   1      0 -> lane A, 1 -> lane B (used when alt_en=0)
//  alt_en       in   1      1 = ignore in_sel; alternate A,B,A,B... per accepted word
//  out_a_valid  out  1      lane A head word valid
//  out_a_ready  in   1      lane A consumer takes head
//  out_a_data   out  WIDTH  lane A head word
//  out_b_valid  out  1      lane B head word valid
//  out_b_ready  in   1      lane B consumer takes head
//  out_b_data   out  WIDTH  lane B head word
//  cnt_a        out  log2(DEPTH)+1  lane A occupancy
//  cnt_b        out  log2(DEPTH)+1  lane B occupancy
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): both FIFOs emptied (cnt_a=cnt_b=0), alternation pointer ptr=0 (lane A).
//    All out_*_valid=0; out_*_data=0. Buffered words are discarded, including on reset mid-stream.
//  - Target lane tgt = alt_en ? ptr : in_sel.
//  - in_ready = (cnt of tgt lane < DEPTH). Depends only on registered state plus in_sel/alt_en.
//    There is no combinational path from out_*_ready to in_ready. A full lane does not accept
//    a word even if it pops in the same cycle.
//  - Push: on in_valid & in_ready, in_data is written at the tail of the tgt lane.
//  - ptr: toggles on every accepted word while alt_en=1; holds while alt_en=0 or no transfer.
//    ptr is not cleared when alt_en changes.
//  - out_x_valid = (cnt_x != 0). out_x_data = head entry when valid, else 0.
//  - Pop: on out_x_valid & out_x_ready, advance the head.
//  - Latency: an accepted word appears on its lane output on the next cycle (1-cycle latency)
//    if the lane was empty.
//  - Same-cycle push and pop on one lane: cnt unchanged; FIFO order preserved;
//    read/write pointers wrap modulo DEPTH.
//  - Push to one lane and pop from the other in the same cycle are independent.
//  - in_valid=0: no state change except pops. Words are never dropped, duplicated or reordered within a lane.
//  - out_x_ready while out_x_valid=0 is ignored.
// TESTING
//  1. Reset: rst_n=0 for 2 clocks with in_valid=1 -> after release cnt_a=cnt_b=0, out_*_valid=0,
//     in_ready=1, nothing stored.
//  2. alt_en=0, out_*_ready=1, send 3,5 (sel=0) then 9 (sel=1) -> lane A emits 3,5 and lane B emits 9,
//     each word 1 cycle after acceptance.
//  3. alt_en=1, ready=1, send 1,2,3,4 -> A gets 1,3 and B gets 2,4. Deassert alt_en after 3 words,
//     then re-assert -> ptr resumes from its held value.
//  4. out_a_ready=0, sel=0, send 7,8,6 -> 7,8 accepted (cnt_a=2); in_ready=0 for 6 while lane A is full.
//     With sel=1, in_ready=1 (lane B not blocked). Raise out_a_ready -> 7 then 8 emitted;
//     6 accepted once a slot is free.
//  5. Lane A at cnt=1: push and pop in the same cycle -> cnt_a stays 1, head order correct;
//     wrap pointers over 10 pushes.
//  6. Fill both lanes, assert rst_n=0 mid-stream -> both lanes empty next cycle; no stale words emitted.

Source files
------------

// File: rtl/rns_demux_1_2_4bit.sv
// Streaming 1:2 demultiplexer for residue digits with a small FIFO per output lane.
// Words are steered by in_sel, or alternate A/B per accepted word when alt_en is set.
module rns_demux_1_2_4bit #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_sel,
   input  logic                     alt_en,
   output logic                     out_a_valid,
   input  logic                     out_a_ready,
   output logic [WIDTH-1:0]         out_a_data,
   output logic                     out_b_valid,
   input  logic                     out_b_ready,
   output logic [WIDTH-1:0]         out_b_data,
   output logic [$clog2(DEPTH):0]   cnt_a,
   output logic [$clog2(DEPTH):0]   cnt_b
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [2][DEPTH];
   logic [AW-1:0]    wr_q  [2];
   logic [AW-1:0]    wr_d  [2];
   logic [AW-1:0]    rd_q  [2];
   logic [AW-1:0]    rd_d  [2];
   logic [CW-1:0]    cnt_q [2];
   logic [CW-1:0]    cnt_d [2];
   logic             ptr_q;
   logic             ptr_d;

   logic             tgt;
   logic             accept;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       valid;
   logic [1:0]       out_ready;

   assign out_ready = {out_b_ready, out_a_ready};

   always_comb begin
      tgt      = alt_en ? ptr_q : in_sel;
      // Full lane refuses even if it pops this cycle: keeps in_ready off the out_ready path.
      in_ready = (cnt_q[tgt] < CW'(DEPTH));
      accept   = in_valid & in_ready;
      push     = {accept & tgt, accept & ~tgt};
      ptr_d    = (accept && alt_en) ? ~ptr_q : ptr_q;
      for (int l = 0; l < 2; l++) begin
         valid[l] = (cnt_q[l] != '0);
         pop[l]   = valid[l] & out_ready[l];
         wr_d[l]  = push[l] ? wr_q[l] + 1'b1 : wr_q[l];
         rd_d[l]  = pop[l] ? rd_q[l] + 1'b1 : rd_q[l];
         cnt_d[l] = cnt_q[l] + CW'(push[l]) - CW'(pop[l]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
         for (int l = 0; l < 2; l++) begin
            wr_q[l]  <= '0;
            rd_q[l]  <= '0;
            cnt_q[l] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         for (int l = 0; l < 2; l++) begin
            wr_q[l]  <= wr_d[l];
            rd_q[l]  <= rd_d[l];
            cnt_q[l] <= cnt_d[l];
         end
      end
   end

   // Storage needs no reset: data outputs are gated by the occupancy count.
   always_ff @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (rst_n && push[l]) begin
            mem_q[l][wr_q[l]] <= in_data;
         end
      end
   end

   always_comb begin
      out_a_valid = valid[0];
      out_b_valid = valid[1];
      out_a_data  = valid[0] ? mem_q[0][rd_q[0]] : '0;
      out_b_data  = valid[1] ? mem_q[1][rd_q[1]] : '0;
      cnt_a       = cnt_q[0];
      cnt_b       = cnt_q[1];
   end

endmodule

// File: tb/tb_rns_demux_1_2_4bit.sv
// Directed self-checking bench for rns_demux_1_2_4bit; expected values are hand-computed.
module tb_rns_demux_1_2_4bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_sel;
   logic       alt_en;
   logic       out_a_valid;
   logic       out_a_ready;
   logic [3:0] out_a_data;
   logic       out_b_valid;
   logic       out_b_ready;
   logic [3:0] out_b_data;
   logic [1:0] cnt_a;
   logic [1:0] cnt_b;

   int n_checks = 0;
   int n_errors = 0;

   rns_demux_1_2_4bit #(
      .WIDTH (4),
      .DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .alt_en      (alt_en),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_a_data  (out_a_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .out_b_data  (out_b_data),
      .cnt_a       (cnt_a),
      .cnt_b       (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_sel   = s;
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b1;
      in_data     = 4'd5;
      in_sel      = 1'b0;
      alt_en      = 1'b0;
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;

      // 1. reset with in_valid high
      tick();
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_cnt_a", 32'(cnt_a), 0);
      check("rst_cnt_b", 32'(cnt_b), 0);
      check("rst_a_valid", 32'(out_a_valid), 0);
      check("rst_b_valid", 32'(out_b_valid), 0);
      check("rst_a_data", 32'(out_a_data), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      tick();
      check("rst_nothing_stored", 32'(cnt_a + cnt_b), 0);

      // 2. per-word select, both consumers ready
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      send(4'd3, 1'b0);
      check("sel_a_valid_3", 32'(out_a_valid), 1);
      check("sel_a_data_3", 32'(out_a_data), 3);
      send(4'd5, 1'b0);
      check("sel_a_data_5", 32'(out_a_data), 5);
      check("sel_cnt_a_5", 32'(cnt_a), 1);
      send(4'd9, 1'b1);
      check("sel_a_empty", 32'(out_a_valid), 0);
      check("sel_b_valid_9", 32'(out_b_valid), 1);
      check("sel_b_data_9", 32'(out_b_data), 9);
      in_valid = 1'b0;
      tick();
      check("sel_b_drained", 32'(out_b_valid), 0);

      // 3. alternation, with ptr held while alt_en is low
      alt_en = 1'b1;
      send(4'd1, 1'b1);
      check("alt_a_1", 32'(out_a_data), 1);
      check("alt_b_empty_1", 32'(out_b_valid), 0);
      send(4'd2, 1'b0);
      check("alt_b_2", 32'(out_b_data), 2);
      check("alt_a_empty_2", 32'(out_a_valid), 0);
      send(4'd3, 1'b1);
      check("alt_a_3", 32'(out_a_data), 3);
      alt_en = 1'b0;
      send(4'd10, 1'b0);
      check("alt_off_a_10", 32'(out_a_data), 10);
      check("alt_off_b_empty", 32'(out_b_valid), 0);
      alt_en = 1'b1;
      send(4'd4, 1'b0);
      check("alt_resume_b_4", 32'(out_b_data), 4);
      check("alt_resume_a_empty", 32'(out_a_valid), 0);
      in_valid = 1'b0;
      alt_en   = 1'b0;
      tick();

      // 4. lane A backpressure
      out_a_ready = 1'b0;
      send(4'd7, 1'b0);
      send(4'd8, 1'b0);
      check("bp_cnt_a_full", 32'(cnt_a), 2);
      check("bp_head_7", 32'(out_a_data), 7);
      in_valid = 1'b1;
      in_data  = 4'd6;
      in_sel   = 1'b0;
      #1;
      check("bp_ready_a_full", 32'(in_ready), 0);
      in_sel = 1'b1;
      #1;
      check("bp_ready_b_free", 32'(in_ready), 1);
      in_sel = 1'b0;
      #1;
      tick();
      check("bp_held_cnt", 32'(cnt_a), 2);
      check("bp_b_untouched", 32'(cnt_b), 0);
      out_a_ready = 1'b1;
      #1;
      check("bp_full_pop_ready", 32'(in_ready), 0);
      tick();
      check("bp_emit_7_then_8", 32'(out_a_data), 8);
      check("bp_cnt_after_pop", 32'(cnt_a), 1);
      check("bp_ready_slot", 32'(in_ready), 1);
      tick();
      check("bp_head_6", 32'(out_a_data), 6);
      check("bp_cnt_6", 32'(cnt_a), 1);
      in_valid = 1'b0;
      tick();
      check("bp_drained", 32'(cnt_a), 0);

      // 5. same-cycle push/pop at cnt=1 with pointer wrap
      send(4'd2, 1'b0);
      for (int i = 0; i < 10; i++) begin
         logic [3:0] d;
         d = 4'((i * 3 + 5) & 15);
         send(d, 1'b0);
         check($sformatf("wrap_cnt_%0d", i), 32'(cnt_a), 1);
         check($sformatf("wrap_head_%0d", i), 32'(out_a_data), 32'(d));
      end
      in_valid = 1'b0;
      tick();
      check("wrap_drained", 32'(out_a_valid), 0);

      // 6. reset mid-stream with both lanes full
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      alt_en      = 1'b1;
      send(4'd11, 1'b0);
      send(4'd12, 1'b0);
      send(4'd13, 1'b0);
      send(4'd14, 1'b0);
      check("fill_cnt_a", 32'(cnt_a), 2);
      check("fill_cnt_b", 32'(cnt_b), 2);
      check("fill_head_a", 32'(out_a_data), 11);
      check("fill_head_b", 32'(out_b_data), 12);
      rst_n       = 1'b0;
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      in_data     = 4'd15;
      tick();
      check("midrst_cnt_a", 32'(cnt_a), 0);
      check("midrst_cnt_b", 32'(cnt_b), 0);
      check("midrst_a_valid", 32'(out_a_valid), 0);
      check("midrst_b_data", 32'(out_b_data), 0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();
      check("postrst_no_stale", 32'({out_a_valid, out_b_valid}), 0);
      send(4'd6, 1'b1);
      check("postrst_ptr_a", 32'(out_a_data), 6);
      check("postrst_ptr_b_empty", 32'(out_b_valid), 0);
      in_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
